// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate tick, pixel/line counters, registered active-low syncs.
// Optional frame_tick output is enabled with the VGA_FRAME_TICK_EN macro.
module vga_sync_gen #(
    parameter int DIV       = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       hsync,
    output logic       vsync,
`ifdef VGA_FRAME_TICK_EN
    output logic       frame_tick,
`endif
    output logic       video_on
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = $clog2(DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DW-1:0] div_cnt;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic [9:0]    h_next;
    logic [9:0]    v_next;

    assign p_tick = (div_cnt == DIV_LAST);

    always_comb begin
        h_next = h_cnt;
        v_next = v_cnt;
        if (p_tick) begin
            if (h_cnt == H_LAST) begin
                h_next = '0;
                v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            end else begin
                h_next = h_cnt + 10'd1;
            end
        end
    end

    // Syncs are decoded from the next counts so they change on the same edge as the coordinates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
        end else begin
            div_cnt <= p_tick ? '0 : div_cnt + DW'(1);
            h_cnt   <= h_next;
            v_cnt   <= v_next;
            hsync   <= !((h_next >= HS_START) && (h_next <= HS_END));
            vsync   <= !((v_next >= VS_START) && (v_next <= VS_END));
        end
    end

    assign pixel_x  = h_cnt;
    assign pixel_y  = v_cnt;
    assign video_on = (h_cnt < H_VIS) && (v_cnt < V_VIS);

`ifdef VGA_FRAME_TICK_EN
    assign frame_tick = p_tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default 640x480 instance and a shrunken-timing instance,
// both compared each cycle against a position-from-elapsed-cycles model.
module tb_vga_sync_gen;

    localparam int S_DIV = 2;
    localparam int S_HD = 16, S_HF = 3, S_HS = 5, S_HB = 4;
    localparam int S_VD = 10, S_VF = 2, S_VS = 2, S_VB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       pt_d, hs_d, vs_d, vo_d, ft_d;
    logic [9:0] px_d, py_d;
    logic       pt_s, hs_s, vs_s, vo_s, ft_s;
    logic [9:0] px_s, py_s;

    int tests  = 0;
    int errors = 0;
    int n      = 0;   // rising edges since the last reset release

    always #5 clk = ~clk;

    vga_sync_gen u_def (
        .clk(clk), .reset(rst), .p_tick(pt_d), .pixel_x(px_d), .pixel_y(py_d),
        .hsync(hs_d), .vsync(vs_d),
`ifdef VGA_FRAME_TICK_EN
        .frame_tick(ft_d),
`endif
        .video_on(vo_d)
    );

    vga_sync_gen #(
        .DIV(S_DIV), .H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
    ) u_small (
        .clk(clk), .reset(rst), .p_tick(pt_s), .pixel_x(px_s), .pixel_y(py_s),
        .hsync(hs_s), .vsync(vs_s),
`ifdef VGA_FRAME_TICK_EN
        .frame_tick(ft_s),
`endif
        .video_on(vo_s)
    );

`ifndef VGA_FRAME_TICK_EN
    assign ft_d = 1'b0;
    assign ft_s = 1'b0;
`endif

    task automatic cmp(string tag, logic [9:0] obs, logic [9:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (n=%0d)", tag, obs, exp, n);
        end
    endtask

    // Beam position is simply the number of completed pixel periods modulo the frame size.
    task automatic check_inst(string nm, int div, int hd, int hf, int hs, int hb,
                              int vd, int vf, int vs, int vb,
                              logic pt, logic [9:0] px, logic [9:0] py,
                              logic hsy, logic vsy, logic vo, logic ft);
        int ht, vt, p, x, y;
        logic e_pt;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        p  = (n / div) % (ht * vt);
        x  = p % ht;
        y  = p / ht;
        e_pt = ((n % div) == div - 1);
        cmp({nm, ".p_tick"},   10'(pt), 10'(e_pt));
        cmp({nm, ".pixel_x"},  px, 10'(x));
        cmp({nm, ".pixel_y"},  py, 10'(y));
        cmp({nm, ".hsync"},    10'(hsy), 10'(!(x >= hd + hf && x < hd + hf + hs)));
        cmp({nm, ".vsync"},    10'(vsy), 10'(!(y >= vd + vf && y < vd + vf + vs)));
        cmp({nm, ".video_on"}, 10'(vo), 10'(x < hd && y < vd));
`ifdef VGA_FRAME_TICK_EN
        cmp({nm, ".frame_tick"}, 10'(ft), 10'(e_pt && x == ht - 1 && y == vt - 1));
`else
        if (ft !== 1'b0) cmp({nm, ".frame_tick_tie"}, 10'(ft), 10'd0);
`endif
    endtask

    task automatic check_all();
        check_inst("def", 4, 640, 16, 96, 48, 480, 10, 2, 33,
                   pt_d, px_d, py_d, hs_d, vs_d, vo_d, ft_d);
        check_inst("small", S_DIV, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB,
                   pt_s, px_s, py_s, hs_s, vs_s, vo_s, ft_s);
    endtask

    task automatic run(int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            check_all();
        end
    endtask

    // Reset raised between clock edges must clear everything without waiting for clk.
    task automatic async_reset(int hold);
        @(negedge clk);
        #($urandom_range(1, 3));
        rst = 1'b1;
        n   = 0;
        #1;
        check_all();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_all();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_all();
        rst = 1'b0;
        n   = 0;

        // A full default line plus spare; covers several complete small frames and wraps.
        run(3400);

        // Reset the small instance's frame in the middle of its vsync pulse.
        for (int guard = 0; guard < 2000; guard++) begin
            if (py_s == 10'(S_VD + S_VF) && vs_s == 1'b0 && px_s == 10'd7) break;
            run(1);
        end
        cmp("mid_vsync_reached", 10'(vs_s), 10'd0);
        async_reset(3);
        run(1200);

        for (int k = 0; k < 8; k++) begin
            run($urandom_range(100, 2500));
            async_reset($urandom_range(0, 4));
        end
        run(2000);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
